// File: rtl/arp_config_mgr_pkg.sv
// arp_cfg_pkg: field sizes, entry widths and entry layouts shared by the ARP config manager
package arp_cfg_pkg;
  localparam int SA_MAC          = 48;
  localparam int SA_IP4          = 32;
  localparam int DA_IP4          = 32;
  localparam int BOILER_PLATE    = 48;
  localparam int CFG_WIDTH       = SA_MAC + SA_IP4 + DA_IP4 + 32 + 2;
  localparam int CAM_ENTRY_WIDTH = 1 + SA_IP4;
  typedef struct packed {
    logic [DA_IP4-1:0] subnet_mask;
    logic [DA_IP4-1:0] dest_ip;
    logic              ip_match;
    logic [SA_IP4-1:0] src_ip;
    logic              mac_match;
    logic [SA_MAC-1:0] src_mac;
  } cfg_t;
  typedef struct packed {
    logic              must_match;
    logic [SA_IP4-1:0] ip4;
  } cam_entry_t;
  typedef enum logic {IDLE, PENDING} state_t;
endpackage

// File: rtl/arp_config_mgr_if.sv
// arp_config_mgr_if: control-plane write channel plus monitored parser stream handshake
//   master: writer/stream side (drives write request and monitored handshake)
//   slave : config manager (drives ready, done, pause)
interface arp_config_mgr_if
  import arp_cfg_pkg::*;
#(
  parameter int SEL_WIDTH = 5,
  parameter int CFG_W     = CFG_WIDTH
);
  logic                 cfg_wr_valid;
  logic                 cfg_wr_ready;
  logic                 cfg_wr_target;
  logic [SEL_WIDTH-1:0] cfg_wr_index;
  logic [CFG_W-1:0]     cfg_wr_data;
  logic                 cfg_wr_done;
  logic                 mon_tvalid;
  logic                 mon_tready;
  logic                 mon_tlast;
  logic                 stream_pause;
  modport master (
    output cfg_wr_valid, cfg_wr_target, cfg_wr_index, cfg_wr_data, mon_tvalid, mon_tready, mon_tlast,
    input  cfg_wr_ready, cfg_wr_done, stream_pause
  );
  modport slave (
    input  cfg_wr_valid, cfg_wr_target, cfg_wr_index, cfg_wr_data, mon_tvalid, mon_tready, mon_tlast,
    output cfg_wr_ready, cfg_wr_done, stream_pause
  );
endinterface

// File: rtl/arp_config_mgr_axis_pkt_tracker.sv
// axis_pkt_tracker: flags that an AXI-Stream packet has started but its tlast beat has not yet handshaken
//   aclk/aresetn : clock, async active-low reset
//   tvalid_i/tready_i/tlast_i : monitored handshake
//   in_pkt_o : high between a non-last beat and the tlast beat
module axis_pkt_tracker (
  input  logic aclk,
  input  logic aresetn,
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic in_pkt_o
);
  logic in_pkt_q;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) in_pkt_q <= 1'b0;
    else if (tvalid_i && tready_i) in_pkt_q <= !tlast_i;
  assign in_pkt_o = in_pkt_q;
endmodule

// File: rtl/arp_config_mgr.sv
// arp_config_mgr: per-stream ARP config bank and CAM, updated only between packets
//   aclk/aresetn    : clock, async active-low reset
//   bus             : write request channel, done pulse, monitored stream, pause request
//   arp_config_sel  : parser config select
//   arp_config_regs : bank entry addressed by arp_config_sel
//   arp_cam_values  : all CAM entries, entry j at [33*j +: 33]
module arp_config_mgr
  import arp_cfg_pkg::*;
#(
  parameter int  AXIS_ID_WIDTH   = 4,
  parameter int  AXIS_DEST_WIDTH = 0,
  localparam int EFF_ID_WIDTH    = AXIS_ID_WIDTH < 1 ? 1 : AXIS_ID_WIDTH,
  localparam int EFF_DEST_WIDTH  = AXIS_DEST_WIDTH < 1 ? 1 : AXIS_DEST_WIDTH,
  localparam int SEL_WIDTH       = EFF_ID_WIDTH + EFF_DEST_WIDTH,
  localparam int NUM_AXIS_ID     = 2 ** AXIS_ID_WIDTH
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  arp_config_mgr_if.slave                        bus,
  input  logic [SEL_WIDTH-1:0]                   arp_config_sel,
  output logic [CFG_WIDTH-1:0]                   arp_config_regs,
  output logic [CAM_ENTRY_WIDTH*NUM_AXIS_ID-1:0] arp_cam_values
);
  state_t                 state_q, state_d;
  logic                   in_pkt, accept, commit, done_q;
  logic                   sh_tgt_q;
  logic [SEL_WIDTH-1:0]   sh_idx_q;
  logic [CFG_WIDTH-1:0]   sh_data_q;
  cfg_t                   bank_q [2**SEL_WIDTH];
  cam_entry_t             cam_q  [NUM_AXIS_ID];
  axis_pkt_tracker u_trk (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .tvalid_i (bus.mon_tvalid),
    .tready_i (bus.mon_tready),
    .tlast_i  (bus.mon_tlast),
    .in_pkt_o (in_pkt)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    accept  = bus.cfg_wr_valid && bus.cfg_wr_ready;
    state_d = accept ? PENDING : commit ? IDLE : state_q;
  end
  // ready is masked by reset so the writer sees no acceptance while held in reset
  always_comb begin
    commit           = state_q == PENDING && !in_pkt;
    bus.cfg_wr_ready = aresetn && state_q == IDLE;
    bus.stream_pause = commit;
    bus.cfg_wr_done  = done_q;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      done_q    <= 1'b0;
      sh_tgt_q  <= 1'b0;
      sh_idx_q  <= '0;
      sh_data_q <= '0;
      for (int i = 0; i < 2**SEL_WIDTH; i++) bank_q[i] <= '0;
      for (int i = 0; i < NUM_AXIS_ID; i++) cam_q[i] <= '0;
    end else begin
      done_q <= commit;
      if (accept) begin
        sh_tgt_q  <= bus.cfg_wr_target;
        sh_idx_q  <= bus.cfg_wr_index;
        sh_data_q <= bus.cfg_wr_data;
      end
      if (commit && !sh_tgt_q) bank_q[sh_idx_q] <= cfg_t'(sh_data_q);
      if (commit && sh_tgt_q) cam_q[sh_idx_q[EFF_ID_WIDTH-1:0]] <= cam_entry_t'(sh_data_q[CAM_ENTRY_WIDTH-1:0]);
    end
  assign arp_config_regs = bank_q[arp_config_sel];
  for (genvar j = 0; j < NUM_AXIS_ID; j++) begin : g_cam
    assign arp_cam_values[CAM_ENTRY_WIDTH*j +: CAM_ENTRY_WIDTH] = cam_q[j];
  end
endmodule

// File: tb/tb_arp_config_mgr.sv
// tb_arp_config_mgr: directed tests of commit timing, packet-boundary deferral, reset and wide select
module tb_arp_config_mgr;
  import arp_cfg_pkg::*;
  localparam int SW = 5;
  localparam int N  = 16;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [SW-1:0] sel;
  logic [CFG_WIDTH-1:0] regs;
  logic [CAM_ENTRY_WIDTH*N-1:0] cam;
  int ntests = 0;
  int nfail = 0;
  arp_config_mgr_if #(.SEL_WIDTH(SW), .CFG_W(CFG_WIDTH)) bus ();
  arp_config_mgr #(.AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(1)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .bus             (bus),
    .arp_config_sel  (sel),
    .arp_config_regs (regs),
    .arp_cam_values  (cam)
  );
  always #5 aclk = ~aclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic cyc();
    @(negedge aclk);
  endtask
  task automatic idle_inputs();
    bus.cfg_wr_valid = 1'b0;
    bus.cfg_wr_target = 1'b0;
    bus.cfg_wr_index = '0;
    bus.cfg_wr_data = '0;
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b0;
    bus.mon_tlast = 1'b0;
  endtask
  task automatic test_reset();
    idle_inputs();
    sel = '0;
    aresetn = 1'b0;
    cyc();
    ntests++; if (bus.cfg_wr_ready !== 1'b0) begin nfail++; $display("FAIL rst_ready: got %b exp 0", bus.cfg_wr_ready); end
    ntests++; if (bus.stream_pause !== 1'b0) begin nfail++; $display("FAIL rst_pause: got %b exp 0", bus.stream_pause); end
    ntests++; if (bus.cfg_wr_done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b exp 0", bus.cfg_wr_done); end
    ntests++; if (cam !== '0) begin nfail++; $display("FAIL rst_cam: got %h exp 0", cam); end
    ntests++; if (regs !== '0) begin nfail++; $display("FAIL rst_regs: got %h exp 0", regs); end
    aresetn = 1'b1;
    #1;
    ntests++; if (bus.cfg_wr_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %b exp 1", bus.cfg_wr_ready); end
    cyc();
  endtask
  task automatic test_cfg_write();
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_target = 1'b0;
    bus.cfg_wr_index = 5'd3;
    bus.cfg_wr_data = 146'h1234;
    sel = 5'd3;
    ntests++; if (bus.cfg_wr_ready !== 1'b1) begin nfail++; $display("FAIL cfg_accept_ready: got %b exp 1", bus.cfg_wr_ready); end
    cyc();
    bus.cfg_wr_valid = 1'b0;
    ntests++; if (bus.cfg_wr_ready !== 1'b0) begin nfail++; $display("FAIL cfg_pend_ready: got %b exp 0", bus.cfg_wr_ready); end
    ntests++; if (bus.stream_pause !== 1'b1) begin nfail++; $display("FAIL cfg_pause: got %b exp 1", bus.stream_pause); end
    ntests++; if (bus.cfg_wr_done !== 1'b0) begin nfail++; $display("FAIL cfg_early_done: got %b exp 0", bus.cfg_wr_done); end
    ntests++; if (regs !== '0) begin nfail++; $display("FAIL cfg_early_regs: got %h exp 0", regs); end
    cyc();
    ntests++; if (bus.cfg_wr_done !== 1'b1) begin nfail++; $display("FAIL cfg_done: got %b exp 1", bus.cfg_wr_done); end
    ntests++; if (bus.stream_pause !== 1'b0) begin nfail++; $display("FAIL cfg_pause_drop: got %b exp 0", bus.stream_pause); end
    ntests++; if (regs !== 146'h1234) begin nfail++; $display("FAIL cfg_regs: got %h exp 1234", regs); end
    ntests++; if (bus.cfg_wr_ready !== 1'b1) begin nfail++; $display("FAIL cfg_ready_back: got %b exp 1", bus.cfg_wr_ready); end
    cyc();
    ntests++; if (bus.cfg_wr_done !== 1'b0) begin nfail++; $display("FAIL cfg_done_pulse: got %b exp 0", bus.cfg_wr_done); end
  endtask
  task automatic test_cam_mid_packet();
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    bus.mon_tlast = 1'b0;
    cyc();
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_target = 1'b1;
    bus.cfg_wr_index = 5'd5;
    bus.cfg_wr_data = 146'h1_0A00_0001;
    cyc();
    bus.cfg_wr_valid = 1'b0;
    ntests++; if (bus.stream_pause !== 1'b0) begin nfail++; $display("FAIL cam_pause_b3: got %b exp 0", bus.stream_pause); end
    ntests++; if (bus.cfg_wr_ready !== 1'b0) begin nfail++; $display("FAIL cam_ready_b3: got %b exp 0", bus.cfg_wr_ready); end
    cyc();
    bus.mon_tlast = 1'b1;
    ntests++; if (bus.stream_pause !== 1'b0) begin nfail++; $display("FAIL cam_pause_b4: got %b exp 0", bus.stream_pause); end
    cyc();
    idle_inputs();
    ntests++; if (bus.stream_pause !== 1'b1) begin nfail++; $display("FAIL cam_pause_gap: got %b exp 1", bus.stream_pause); end
    ntests++; if (cam[5*33 +: 33] !== 33'h0) begin nfail++; $display("FAIL cam_early: got %h exp 0", cam[5*33 +: 33]); end
    cyc();
    ntests++; if (bus.cfg_wr_done !== 1'b1) begin nfail++; $display("FAIL cam_done: got %b exp 1", bus.cfg_wr_done); end
    ntests++; if (cam[5*33 +: 33] !== 33'h1_0A00_0001) begin nfail++; $display("FAIL cam_value: got %h exp 10a000001", cam[5*33 +: 33]); end
    ntests++; if (cam[4*33 +: 33] !== 33'h0) begin nfail++; $display("FAIL cam_neighbor: got %h exp 0", cam[4*33 +: 33]); end
    cyc();
  endtask
  task automatic test_single_beat();
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_target = 1'b0;
    bus.cfg_wr_index = 5'd7;
    bus.cfg_wr_data = 146'hBEEF;
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    bus.mon_tlast = 1'b1;
    sel = 5'd7;
    cyc();
    idle_inputs();
    ntests++; if (bus.stream_pause !== 1'b1) begin nfail++; $display("FAIL single_pause: got %b exp 1", bus.stream_pause); end
    cyc();
    ntests++; if (bus.cfg_wr_done !== 1'b1) begin nfail++; $display("FAIL single_done: got %b exp 1", bus.cfg_wr_done); end
    ntests++; if (regs !== 146'hBEEF) begin nfail++; $display("FAIL single_regs: got %h exp beef", regs); end
    cyc();
  endtask
  task automatic test_back_to_back();
    int wr_n = 0, dones = 0, beat = 0, tl = 0, tl_at_d1 = 0, t = 0;
    bit early_ready = 0;
    while (dones < 2 && t < 80) begin
      if (bus.cfg_wr_done === 1'b1) begin
        dones++;
        if (dones == 1) tl_at_d1 = tl;
      end
      if (wr_n == 1 && dones == 0 && bus.cfg_wr_ready === 1'b1) early_ready = 1;
      bus.mon_tvalid = !bus.stream_pause;
      bus.mon_tready = !bus.stream_pause;
      bus.mon_tlast = beat == 2;
      bus.cfg_wr_valid = wr_n < 2;
      bus.cfg_wr_target = 1'b0;
      bus.cfg_wr_index = wr_n == 0 ? 5'd10 : 5'd11;
      bus.cfg_wr_data = wr_n == 0 ? 146'hAAAA_0001 : 146'hBBBB_0002;
      if (bus.cfg_wr_valid && bus.cfg_wr_ready) wr_n++;
      if (!bus.stream_pause) begin
        if (beat == 2) tl++;
        beat = beat == 2 ? 0 : beat + 1;
      end
      cyc();
      t++;
    end
    idle_inputs();
    ntests++; if (dones != 2) begin nfail++; $display("FAIL b2b_dones: got %0d exp 2", dones); end
    ntests++; if (early_ready) begin nfail++; $display("FAIL b2b_ready: got 1 before first done exp 0"); end
    ntests++; if (tl - tl_at_d1 < 1) begin nfail++; $display("FAIL b2b_gap: got %0d packets between commits exp >=1", tl - tl_at_d1); end
    while (bus.stream_pause === 1'b0 && beat != 0 && t < 100) begin
      bus.mon_tvalid = 1'b1;
      bus.mon_tready = 1'b1;
      bus.mon_tlast = beat == 2;
      beat = beat == 2 ? 0 : beat + 1;
      cyc();
      t++;
    end
    idle_inputs();
    cyc();
    sel = 5'd10;
    #1;
    ntests++; if (regs !== 146'hAAAA_0001) begin nfail++; $display("FAIL b2b_regs10: got %h exp aaaa0001", regs); end
    sel = 5'd11;
    #1;
    ntests++; if (regs !== 146'hBBBB_0002) begin nfail++; $display("FAIL b2b_regs11: got %h exp bbbb0002", regs); end
    cyc();
  endtask
  task automatic test_reset_pending();
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_target = 1'b0;
    bus.cfg_wr_index = 5'd20;
    bus.cfg_wr_data = 146'h5555;
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    bus.mon_tlast = 1'b0;
    sel = 5'd20;
    cyc();
    idle_inputs();
    ntests++; if (bus.cfg_wr_ready !== 1'b0) begin nfail++; $display("FAIL rp_pending: got %b exp 0", bus.cfg_wr_ready); end
    aresetn = 1'b0;
    #1;
    ntests++; if (bus.stream_pause !== 1'b0) begin nfail++; $display("FAIL rp_pause: got %b exp 0", bus.stream_pause); end
    cyc();
    aresetn = 1'b1;
    #1;
    ntests++; if (bus.cfg_wr_ready !== 1'b1) begin nfail++; $display("FAIL rp_ready: got %b exp 1", bus.cfg_wr_ready); end
    ntests++; if (regs !== '0) begin nfail++; $display("FAIL rp_regs: got %h exp 0", regs); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      ntests++; if (bus.cfg_wr_done !== 1'b0) begin nfail++; $display("FAIL rp_no_done: got %b exp 0 at cycle %0d", bus.cfg_wr_done, i); end
    end
    ntests++; if (regs !== '0) begin nfail++; $display("FAIL rp_regs_after: got %h exp 0", regs); end
  endtask
  task automatic test_idx31();
    logic [CFG_WIDTH-1:0] pat;
    pat = {2'b11, 48'hFEDC_BA98_7654, 32'hC0A8_0101, 32'h0A00_00FE, 32'hDEAD_BEEF};
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_target = 1'b0;
    bus.cfg_wr_index = 5'd31;
    bus.cfg_wr_data = pat;
    sel = 5'd31;
    cyc();
    idle_inputs();
    cyc();
    ntests++; if (bus.cfg_wr_done !== 1'b1) begin nfail++; $display("FAIL i31_done: got %b exp 1", bus.cfg_wr_done); end
    ntests++; if (regs !== pat) begin nfail++; $display("FAIL i31_regs: got %h exp %h", regs, pat); end
    sel = 5'd30;
    #1;
    ntests++; if (regs !== '0) begin nfail++; $display("FAIL i30_regs: got %h exp 0", regs); end
    cyc();
  endtask
  initial begin
    test_reset();
    test_cfg_write();
    test_cam_mid_packet();
    test_single_beat();
    test_back_to_back();
    test_reset_pending();
    test_idx31();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/arp_config_mgr.md
Name: arp_config_mgr

Overview:
- Owns the per-stream configuration bank that feeds the ARP parser's ACL/CAM inputs (arp_config_regs, arp_cam_values).
- Accepts single-entry writes from the control plane and holds each one pending until a packet boundary, so that no packet is parsed against a half-updated configuration.
- Sits beside the ARP parser wrapper. It monitors the parser's input handshake and drives a pause request that the integrator gates into that stream.

Parameters:
- AXIS_ID_WIDTH, 4, tid width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH CAM entries.
- AXIS_DEST_WIDTH, 0, tdest width; EFF_* widths are clamped to a minimum of 1.
- SEL_WIDTH, derived = EFF_ID_WIDTH+EFF_DEST_WIDTH; config bank depth = 2**SEL_WIDTH.
- CFG_WIDTH, derived = 48+32+32+32+2 = 146, config entry width.
- CAM_ENTRY_WIDTH, derived = 33, CAM entry width ({must_match, ip4}).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- cfg_wr_valid  in  1  write request valid.
- cfg_wr_ready  out  1  write request accepted when valid && ready.
- cfg_wr_target  in  1  0 = config bank, 1 = CAM entry.
- cfg_wr_index  in  SEL_WIDTH  entry index; for CAM writes only the low AXIS_ID_WIDTH bits are used.
- cfg_wr_data  in  CFG_WIDTH  entry data; for CAM writes only the low 33 bits are used.
- cfg_wr_done  out  1  one-cycle pulse when a committed write becomes visible.
- mon_tvalid  in  1  parser input tvalid.
- mon_tready  in  1  parser input tready.
- mon_tlast  in  1  parser input tlast.
- stream_pause  out  1  integrator forces no handshake on the monitored stream while this is high.
- arp_config_sel  in  SEL_WIDTH  parser config select.
- arp_config_regs  out  CFG_WIDTH  config bank entry addressed by arp_config_sel.
- arp_cam_values  out  33*NUM_AXIS_ID  all CAM entries; entry j is at [33*j +: 33].

Behaviour:
- Packet tracking: in_pkt register.
  - Set on a monitored handshake (mon_tvalid && mon_tready) with !mon_tlast.
  - Cleared on a handshake with mon_tlast.
  - Unchanged otherwise. A single-beat packet leaves in_pkt at 0.
- FSM, two states: IDLE, PENDING.
  - IDLE: cfg_wr_ready = 1. On accept, latch target/index/data into the shadow register and go to PENDING.
  - PENDING: cfg_wr_ready = 0; stream_pause = !in_pkt (combinational).
  - PENDING, commit condition: when !in_pkt, write the shadow into the bank on that clock edge and return to IDLE.
  - cfg_wr_done pulses in the next cycle; the new value is visible on the outputs from that cycle.
- Timing: accept in cycle N with in_pkt = 0 → pause high in N+1, commit at the end of N+1, done and visibility in N+2.
- Accept in the same cycle as a packet's first beat (non-last): in_pkt becomes 1 and the commit waits until the tlast handshake.
- PENDING with in_pkt = 1 and the tlast beat handshaking this cycle: no commit this cycle. in_pkt clears, then pause/commit happen in the following cycle.
- The handshake-free guarantee while pause is high belongs to the integrator. If a handshake occurs anyway, in_pkt still updates from it; the commit still proceeds.
- Outputs:
  - arp_config_regs is a combinational read of bank[arp_config_sel].
  - arp_cam_values is a direct concatenation of the CAM registers.
  - A write to an entry is never visible partially.
- Reset (async assert, synchronous deassert handled by the reset source):
  - All bank and CAM entries clear to 0, i.e. all match/must_match bits off.
  - in_pkt = 0, FSM = IDLE, shadow cleared.
  - Output values during reset: cfg_wr_ready = 0, stream_pause = 0, cfg_wr_done = 0.
  - After release, cfg_wr_ready = 1 from the first cycle.
- Reset mid-PENDING drops the pending write with no done pulse.
- Only one write is outstanding at a time; back-to-back writes therefore commit one per packet gap.

Decomposition:
- Package arp_cfg_pkg holds:
  - Field sizes: SA_MAC 48, SA_IP4 32, DA_IP4 32, BOILER_PLATE 48.
  - CFG_WIDTH and CAM_ENTRY_WIDTH.
  - Packed struct typedefs matching the config field order {subnet_mask, dest_ip, ip_match, src_ip, mac_match, src_mac} and the CAM entry {must_match, ip4}.
- One sub-module: axis_pkt_tracker (the in_pkt flag). It is reusable by other NMU config managers.

Test Plan:
- Write config index 3 data 0x1234 with the stream idle → ready drops; pause high for 1 cycle; done pulses 2 cycles after accept; sel = 3 reads 0x1234.
- Start a 4-beat packet, then write CAM index 5 = {1, 0x0A000001} on beat 2 → pause stays low through beat 4; CAM[5] updates the cycle after the tlast handshake plus 1; no pause asserted mid-packet.
- Accept coinciding with a single-beat packet (tlast on the first beat) → in_pkt stays 0; commit in the next cycle.
- Two writes back-to-back with continuous 3-beat packets gated by pause → each commits in a separate gap; ready is 0 until the first done.
- aresetn pulsed low while PENDING → the entry keeps its old value 0; no done pulse; ready = 1 after release.
- Write sel index 31 with AXIS_DEST_WIDTH = 1 → arp_config_regs correct at sel = 31; sel = 30 unchanged.
